// File: rtl/capture_sequencer.sv
// capture_sequencer
//   Multi-stage sequential trigger and capture controller for a SUMP-style logic
//   analyser. It takes decoded commands, walks a chain of trigger stages (each
//   with mask/value match and an optional sample delay), and streams samples into
//   a ring-buffer capture RAM. It then reads the captured window back to the UART
//   transmitter over a valid/ready handshake.
// Ports
//   clock, reset            system clock, synchronous active-high reset
//   cmd_valid/opcode/command decoded command strobe, opcode and 32-bit argument
//   sample_valid/sample_data sampler strobe and sample word
//   wr_en/wr_addr           capture RAM write strobe and write pointer (wraps)
//   rd_addr                 capture RAM readout address
//   tx_valid/tx_ready       readout word handshake towards the UART
//   armed/triggered/stage   status: waiting for trigger / capturing or reading out /
//                           current trigger stage
module capture_sequencer #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int NUM_STAGES   = 4,
  parameter int ADDR_WIDTH   = 12,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cmd_valid,
  input  logic [7:0]              opcode,
  input  logic [31:0]             command,
  input  logic                    sample_valid,
  input  logic [SAMPLE_WIDTH-1:0] sample_data,
  output logic                    wr_en,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    armed,
  output logic                    triggered,
  output logic [2:0]              stage
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_DELAY, S_CAPTURE, S_READOUT
  } state_e;

  state_e                                   state_q, state_d;
  logic [NUM_STAGES-1:0][SAMPLE_WIDTH-1:0]  mask_q, mask_d;
  logic [NUM_STAGES-1:0][SAMPLE_WIDTH-1:0]  value_q, value_d;
  logic [NUM_STAGES-1:0][15:0]              delay_q, delay_d;
  logic [NUM_STAGES-1:0]                    en_q, en_d;
  logic [CNT_WIDTH-1:0]                     read_cnt_q, read_cnt_d;
  logic [2:0]                               stage_q, stage_d;
  logic [15:0]                              dcnt_q, dcnt_d;
  logic [ADDR_WIDTH-1:0]                    wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0]                    rd_addr_q, rd_addr_d;
  // pre-trigger writes, saturating at DEPTH (one extra bit)
  logic [ADDR_WIDTH:0]                      pre_cnt_q, pre_cnt_d;
  logic [CNT_WIDTH-1:0]                     post_cnt_q, post_cnt_d;

  logic                    is_stop, is_arm, is_abort;
  logic [SAMPLE_WIDTH-1:0] cur_mask, cur_value;
  logic [15:0]             cur_delay;
  logic                    cur_match;
  logic [2:0]              first_idx, nxt_idx;
  logic                    any_en, has_nxt;
  logic [CNT_WIDTH-1:0]    rc_eff;
  logic                    trig, adv, go_ro;
  logic [31:0]             rc32, room32, pre32;
  logic [ADDR_WIDTH-1:0]   rd_start;
  logic                    unused_cmd;

  assign unused_cmd = ^command;

  assign is_stop  = cmd_valid && (opcode == 8'h00);
  assign is_arm   = cmd_valid && (opcode == 8'h01);
  assign is_abort = cmd_valid && (opcode == 8'h05);
  assign rc_eff   = (read_cnt_q == '0) ? CNT_WIDTH'(1) : read_cnt_q;

  // Current-stage match and the first / next enabled stage lookups.
  always_comb begin
    cur_mask  = '0;
    cur_value = '0;
    cur_delay = '0;
    first_idx = 3'd0;
    any_en    = 1'b0;
    nxt_idx   = 3'd0;
    has_nxt   = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (stage_q == 3'(i)) begin
        cur_mask  = mask_q[i];
        cur_value = value_q[i];
        cur_delay = delay_q[i];
      end
    end
    // descending scan so the lowest qualifying index wins
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (en_q[i]) begin
        first_idx = 3'(i);
        any_en    = 1'b1;
      end
      if (en_q[i] && (3'(i) > stage_q)) begin
        nxt_idx = 3'(i);
        has_nxt = 1'b1;
      end
    end
    cur_match = ((sample_data ^ cur_value) & cur_mask) == '0;
  end

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    value_d    = value_q;
    delay_d    = delay_q;
    en_d       = en_q;
    read_cnt_d = read_cnt_q;
    stage_d    = stage_q;
    dcnt_d     = dcnt_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    pre_cnt_d  = pre_cnt_q;
    post_cnt_d = post_cnt_q;
    wr_en      = 1'b0;
    trig       = 1'b0;
    adv        = 1'b0;
    go_ro      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && (opcode[7:5] == 3'b110)) begin
          for (int s = 0; s < NUM_STAGES; s++) begin
            if (opcode[4:2] == 3'(s)) begin
              case (opcode[1:0])
                2'd0: mask_d[s]  = command[SAMPLE_WIDTH-1:0];
                2'd1: value_d[s] = command[SAMPLE_WIDTH-1:0];
                2'd2: begin
                  delay_d[s] = command[15:0];
                  en_d[s]    = command[27];
                end
                default: ;
              endcase
            end
          end
        end
        if (cmd_valid && (opcode == 8'h81)) read_cnt_d = command[CNT_WIDTH-1:0];
        if (is_arm) begin
          state_d    = S_ARMED;
          stage_d    = first_idx;
          wr_addr_d  = '0;
          pre_cnt_d  = '0;
          post_cnt_d = '0;
          dcnt_d     = '0;
        end
      end
      S_ARMED: begin
        if (sample_valid) begin
          wr_en     = 1'b1;
          wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
          if (!any_en) trig = 1'b1;
          else if (cur_match) begin
            if (cur_delay == '0) adv = 1'b1;
            else begin
              state_d = S_DELAY;
              dcnt_d  = cur_delay;
            end
          end
        end
      end
      S_DELAY: begin
        if (sample_valid) begin
          wr_en     = 1'b1;
          wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
          if (dcnt_q <= 16'd1) adv = 1'b1;
          else dcnt_d = dcnt_q - 16'd1;
        end
      end
      S_CAPTURE: begin
        if (sample_valid) begin
          wr_en      = 1'b1;
          wr_addr_d  = wr_addr_q + ADDR_WIDTH'(1);
          post_cnt_d = post_cnt_q + CNT_WIDTH'(1);
          if (post_cnt_d >= rc_eff) go_ro = 1'b1;
        end
      end
      S_READOUT: begin
        if (tx_ready) begin
          if (rd_addr_q == (wr_addr_q - ADDR_WIDTH'(1))) state_d = S_IDLE;
          else rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A completed stage moves to the next enabled one; past the last it triggers.
    if (adv) begin
      if (has_nxt) begin
        stage_d = nxt_idx;
        state_d = S_ARMED;
      end else begin
        trig = 1'b1;
      end
    end

    // Every pre-trigger write counts; the trigger sample itself is post-sample #1.
    if (sample_valid && ((state_q == S_ARMED) || (state_q == S_DELAY)) && !trig &&
        (pre_cnt_q != (ADDR_WIDTH+1)'(DEPTH)))
      pre_cnt_d = pre_cnt_q + (ADDR_WIDTH+1)'(1);

    if (trig) begin
      post_cnt_d = CNT_WIDTH'(1);
      if (rc_eff == CNT_WIDTH'(1)) go_ro = 1'b1;
      else state_d = S_CAPTURE;
    end

    // Abort overrides any trigger in the same cycle.
    if (is_abort && ((state_q == S_ARMED) || (state_q == S_DELAY) || (state_q == S_CAPTURE)))
      go_ro = 1'b1;

    // Readout window: pre-trigger history limited to what fits beside the post samples.
    rc32   = 32'(rc_eff);
    room32 = (rc32 >= 32'(DEPTH)) ? 32'd0 : (32'(DEPTH) - rc32);
    pre32  = 32'(pre_cnt_d);
    if (pre32 > room32) pre32 = room32;
    rd_start = wr_addr_d - rc32[ADDR_WIDTH-1:0] - pre32[ADDR_WIDTH-1:0];

    if (go_ro) begin
      state_d   = S_READOUT;
      rd_addr_d = rd_start;
    end

    // Stop wins over everything, including a same-cycle sample; config is kept.
    if (is_stop) begin
      state_d    = S_IDLE;
      wr_en      = 1'b0;
      wr_addr_d  = '0;
      rd_addr_d  = '0;
      stage_d    = '0;
      dcnt_d     = '0;
      pre_cnt_d  = '0;
      post_cnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      mask_q     <= '0;
      value_q    <= '0;
      delay_q    <= '0;
      en_q       <= '0;
      read_cnt_q <= '0;
      stage_q    <= '0;
      dcnt_q     <= '0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      pre_cnt_q  <= '0;
      post_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      value_q    <= value_d;
      delay_q    <= delay_d;
      en_q       <= en_d;
      read_cnt_q <= read_cnt_d;
      stage_q    <= stage_d;
      dcnt_q     <= dcnt_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      pre_cnt_q  <= pre_cnt_d;
      post_cnt_q <= post_cnt_d;
    end
  end

  assign wr_addr   = wr_addr_q;
  assign rd_addr   = rd_addr_q;
  assign tx_valid  = (state_q == S_READOUT);
  assign armed     = (state_q == S_ARMED) || (state_q == S_DELAY);
  assign triggered = (state_q == S_CAPTURE) || (state_q == S_READOUT);
  assign stage     = stage_q;

endmodule
